// File: rtl/vec_grid_pkg.sv
// vec_grid_pkg: shared constants, state/entry types and the box-address helper for vec_grid_scheduler.
// Contents: frame/grid geometry, write-side latency offsets, FSM state enum, pending-write FIFO entry,
// and grid_addr(row, col) = row*GRID_COLS + col built from shifts and adds.
package vec_grid_pkg;
   localparam int FRAME_WIDTH    = 640;
   localparam int FRAME_HEIGHT   = 480;
   localparam int BOX_SHIFT      = 5;
   localparam int GRID_COLS      = FRAME_WIDTH >> BOX_SHIFT;
   localparam int GRID_ROWS      = FRAME_HEIGHT >> BOX_SHIFT;
   localparam int GRID_ENTRIES   = GRID_COLS * GRID_ROWS;
   localparam int ADDR_WIDTH     = 9;
   localparam int VEC_CORD_WIDTH = 5;
   localparam int X_CORD_WIDTH   = 10;
   localparam int Y_CORD_WIDTH   = 10;
   localparam int X_OFFSET       = 212;
   localparam int Y_OFFSET       = 10;
   localparam int FIFO_DEPTH     = 4;
   localparam int IDX_WIDTH      = X_CORD_WIDTH - BOX_SHIFT;

   typedef enum logic [1:0] {IDLE, ACTIVE, CLEAR} state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]     addr;
      logic [VEC_CORD_WIDTH-1:0] vx;
      logic [VEC_CORD_WIDTH-1:0] vy;
   } fifo_entry_t;

   // row*20 = row*16 + row*4, so no multiplier is needed for the 20-wide grid
   function automatic logic [ADDR_WIDTH-1:0] grid_addr(input logic [IDX_WIDTH-1:0] row,
                                                       input logic [IDX_WIDTH-1:0] col);
      return ADDR_WIDTH'({row, 4'b0}) + ADDR_WIDTH'({row, 2'b0}) + ADDR_WIDTH'(col);
   endfunction
endpackage

// File: rtl/vec_grid_wr_fifo.sv
// vec_grid_wr_fifo: synchronous FIFO of pending grid writes; push and pop may occur in the same cycle.
// Ports: clk, rst (async, active high), push/din (enqueue), pop/dout (dequeue, dout shows head),
// full, empty.
module vec_grid_wr_fifo
   import vec_grid_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  fifo_entry_t din,
   input  logic        pop,
   output fifo_entry_t dout,
   output logic        full,
   output logic        empty
);
   localparam int PW = $clog2(DEPTH);

   fifo_entry_t   mem_q [DEPTH];
   logic [PW:0]   wr_q, wr_d, rd_q, rd_d;

   // pointers carry one extra wrap bit to tell full from empty
   always_comb begin
      wr_d  = wr_q + (PW+1)'(push);
      rd_d  = rd_q + (PW+1)'(pop);
      empty = wr_q == rd_q;
      full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
      dout  = mem_q[rd_q[PW-1:0]];
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end

   // when full, push and pop address the same slot; the head is read before it is overwritten
   always_ff @(posedge clk)
      if (push) mem_q[wr_q[PW-1:0]] <= din;

   a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
endmodule

// File: rtl/vec_grid_scheduler.sv
// vec_grid_scheduler: sequences a single-port vector-grid RAM between never-stalling display reads
// and FIFO-buffered sampled-vector writes drained into idle RAM cycles.
// Ports: clk, rst (async, active high); pixel side pix_valid, VS, x_cord, y_cord, vec_x, vec_y;
// RAM side mem_en, mem_we, mem_addr, mem_wdata, mem_rdata; display side disp_vec_x, disp_vec_y,
// disp_valid; status overflow (sticky drop flag per frame), busy.
// Build option: define VEC_GRID_CLEAR_EN to zero the whole grid after reset (CLEAR state).
module vec_grid_scheduler
   import vec_grid_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        pix_valid,
   input  logic                        VS,
   input  logic [X_CORD_WIDTH-1:0]     x_cord,
   input  logic [Y_CORD_WIDTH-1:0]     y_cord,
   input  logic [VEC_CORD_WIDTH-1:0]   vec_x,
   input  logic [VEC_CORD_WIDTH-1:0]   vec_y,
   output logic                        mem_en,
   output logic                        mem_we,
   output logic [ADDR_WIDTH-1:0]       mem_addr,
   output logic [2*VEC_CORD_WIDTH-1:0] mem_wdata,
   input  logic [2*VEC_CORD_WIDTH-1:0] mem_rdata,
   output logic [VEC_CORD_WIDTH-1:0]   disp_vec_x,
   output logic [VEC_CORD_WIDTH-1:0]   disp_vec_y,
   output logic                        disp_valid,
   output logic                        overflow,
   output logic                        busy
);
`ifdef VEC_GRID_CLEAR_EN
   localparam state_t RESET_STATE = CLEAR;
`else
   localparam state_t RESET_STATE = IDLE;
`endif

   state_t                      state_q, state_d;
   logic                        vs_q, vs_rise;
   logic                        overflow_q, overflow_d;
   logic                        rd_q, rd_d;
   logic [2*VEC_CORD_WIDTH-1:0] hold_q, hold_d;
   logic [X_CORD_WIDTH-1:0]     wx;
   logic [Y_CORD_WIDTH-1:0]     wy;
   logic                        rd_req, sample, push, pop, full, empty, clearing;
   logic [ADDR_WIDTH-1:0]       clr_addr;
   fifo_entry_t                 din, dout;
`ifdef VEC_GRID_CLEAR_EN
   logic [ADDR_WIDTH-1:0]       clr_addr_q, clr_addr_d;
`endif

   vec_grid_wr_fifo u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (din),
      .pop   (pop),
      .dout  (dout),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
`ifdef VEC_GRID_CLEAR_EN
      clearing = (state_q == CLEAR) & ~rst;
      clr_addr = clr_addr_q;
`else
      clearing = 1'b0;
      clr_addr = '0;
`endif
      vs_rise = VS & ~vs_q;
      // combinational RAM controls are gated so they drop to zero the moment rst asserts
      rd_req = ~rst & pix_valid & (x_cord[BOX_SHIFT-1:0] == '0);
      sample = (state_q == ACTIVE) & pix_valid & (x_cord[BOX_SHIFT-1:0] == '0)
               & (y_cord[BOX_SHIFT-1:0] == '0);
      // write-side coordinates are pulled back by the pipeline latency, wrapping into the frame
      wx = (x_cord >= X_CORD_WIDTH'(X_OFFSET)) ? x_cord - X_CORD_WIDTH'(X_OFFSET)
                                               : x_cord + X_CORD_WIDTH'(FRAME_WIDTH - X_OFFSET);
      wy = (y_cord >= Y_CORD_WIDTH'(Y_OFFSET)) ? y_cord - Y_CORD_WIDTH'(Y_OFFSET)
                                               : y_cord + Y_CORD_WIDTH'(FRAME_HEIGHT - Y_OFFSET);
      din.addr = grid_addr(wy[Y_CORD_WIDTH-1:BOX_SHIFT], wx[X_CORD_WIDTH-1:BOX_SHIFT]);
      din.vx   = vec_x;
      din.vy   = vec_y;
      pop  = ~rd_req & ~clearing & ~empty;
      push = sample & (~full | pop);
      // a drop wins over the frame-start clear in the same cycle
      overflow_d = (sample & full & ~pop) | (overflow_q & ~(vs_rise & (state_q == ACTIVE)));
      state_d = (state_q == IDLE && vs_rise) ? ACTIVE : state_q;
`ifdef VEC_GRID_CLEAR_EN
      clr_addr_d = clr_addr_q + ADDR_WIDTH'(clearing & ~rd_req);
      if (clearing && !rd_req && clr_addr_q == ADDR_WIDTH'(GRID_ENTRIES - 1)) state_d = IDLE;
`endif
      mem_en    = rd_req | clearing | pop;
      mem_we    = ~rd_req & (clearing | pop);
      mem_addr  = rd_req ? grid_addr(y_cord[Y_CORD_WIDTH-1:BOX_SHIFT], x_cord[X_CORD_WIDTH-1:BOX_SHIFT])
                         : pop ? dout.addr : clr_addr;
      mem_wdata = pop ? {dout.vx, dout.vy} : '0;
      // read data is shown straight through in the cycle after the read and held afterwards
      rd_d       = rd_req;
      hold_d     = rd_q ? mem_rdata : hold_q;
      disp_vec_x = hold_d[2*VEC_CORD_WIDTH-1:VEC_CORD_WIDTH];
      disp_vec_y = hold_d[VEC_CORD_WIDTH-1:0];
      disp_valid = rd_q;
      overflow   = overflow_q;
      busy       = ~empty | clearing;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q    <= RESET_STATE;
         vs_q       <= 1'b0;
         overflow_q <= 1'b0;
         rd_q       <= 1'b0;
         hold_q     <= '0;
      end else begin
         state_q    <= state_d;
         vs_q       <= VS;
         overflow_q <= overflow_d;
         rd_q       <= rd_d;
         hold_q     <= hold_d;
      end

`ifdef VEC_GRID_CLEAR_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) clr_addr_q <= '0;
      else clr_addr_q <= clr_addr_d;
`endif
endmodule

// File: tb/tb_vec_grid_scheduler.sv
// tb_vec_grid_scheduler: table-driven and sequence checks for vec_grid_scheduler with a RAM model
// and a queue of expected writes that is compared whenever the DUT issues a write.
module tb_vec_grid_scheduler;
   import vec_grid_pkg::*;

   logic       clk = 0, rst = 1, pix_valid = 0, VS = 0;
   logic [9:0] x_cord = 0, y_cord = 0;
   logic [4:0] vec_x = 0, vec_y = 0;
   logic       mem_en, mem_we, disp_valid, overflow, busy;
   logic [8:0] mem_addr;
   logic [9:0] mem_wdata, mem_rdata;
   logic [4:0] disp_vec_x, disp_vec_y;
   logic [9:0] ram [512];
   logic [9:0] rdata_q = 0;
   int         nvec = 0, nerr = 0;
   logic       st_active = 0;
   logic [18:0] exp_q [$];

   typedef struct {logic pv; int x; int y; logic en; logic [8:0] addr;} vec_t;
   vec_t tbl [9];

   vec_grid_scheduler dut (
      .clk(clk), .rst(rst), .pix_valid(pix_valid), .VS(VS), .x_cord(x_cord), .y_cord(y_cord),
      .vec_x(vec_x), .vec_y(vec_y), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .disp_vec_x(disp_vec_x),
      .disp_vec_y(disp_vec_y), .disp_valid(disp_valid), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   assign mem_rdata = rdata_q;
   always @(posedge clk) begin
      if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) rdata_q <= ram[mem_addr];
   end

   function automatic logic [8:0] waddr(int x, int y);
      return 9'((((y + 480 - 10) % 480) / 32) * 20 + ((x + 640 - 212) % 640) / 32);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic pv, int x, int y, int vx, int vy);
      pix_valid = pv;
      x_cord = 10'(x);
      y_cord = 10'(y);
      vec_x = 5'(vx);
      vec_y = 5'(vy);
      if (pv && st_active && x % 32 == 0 && y % 32 == 0 && exp_q.size() < 4)
         exp_q.push_back({waddr(x, y), 5'(vx), 5'(vy)});
   endtask

   // one clock: compare any DUT write against the head of the expected queue at the falling edge
   task automatic cyc();
      logic [18:0] e;
      @(negedge clk);
      if (mem_en && mem_we) begin
         if (exp_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_write: addr %0d data %0h, none pending", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(e[18:10]));
            chk("wr_data", 32'(mem_wdata), 32'(e[9:0]));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_mem_en"}, 32'(mem_en), 0);
      chk({tag, "_mem_we"}, 32'(mem_we), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_overflow"}, 32'(overflow), 0);
      chk({tag, "_disp_valid"}, 32'(disp_valid), 0);
      chk({tag, "_disp_x"}, 32'(disp_vec_x), 0);
      chk({tag, "_disp_y"}, 32'(disp_vec_y), 0);
   endtask

`ifdef VEC_GRID_CLEAR_EN
   task automatic clear_sweep();
      int idx = 0;
      for (int c = 0; c < 400; c++) begin
         VS = (c == 100);
         pix_valid = (c % 7 == 0);
         x_cord = 0;
         y_cord = 0;
         @(negedge clk);
         if (!busy) break;
         if (mem_en && mem_we) begin
            chk("clr_addr", 32'(mem_addr), 32'(idx));
            chk("clr_data", 32'(mem_wdata), 0);
            idx++;
         end
         @(posedge clk);
         #1;
      end
      VS = 0;
      pix_valid = 0;
      chk("clr_count", 32'(idx), 300);
      chk("clr_busy_done", 32'(busy), 0);
   endtask
`endif

   initial begin
      tbl[0] = '{1, 0, 0, 1, 0};
      tbl[1] = '{1, 32, 32, 1, 21};
      tbl[2] = '{1, 5, 0, 0, 0};
      tbl[3] = '{0, 64, 0, 0, 0};
      tbl[4] = '{1, 608, 448, 1, 299};
      tbl[5] = '{1, 320, 100, 1, 70};
      tbl[6] = '{1, 31, 31, 0, 0};
      tbl[7] = '{1, 608, 0, 1, 19};
      tbl[8] = '{1, 0, 479, 1, 280};
      #12;
      chk_zero("reset");
      @(posedge clk);
      #1;
      rst = 0;
`ifdef VEC_GRID_CLEAR_EN
      clear_sweep();
`endif
      // read addressing in IDLE: no sampling, empty FIFO
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].pv, tbl[i].x, tbl[i].y, 0, 0);
         #1;
         chk($sformatf("tbl%0d_en", i), 32'(mem_en), 32'(tbl[i].en));
         chk($sformatf("tbl%0d_we", i), 32'(mem_we), 0);
         if (tbl[i].en) chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
         if (i > 0) chk($sformatf("tbl%0d_disp_valid", i), 32'(disp_valid), 32'(tbl[i-1].en));
         cyc();
      end
      // frame start
      drive(0, 0, 0, 0, 0);
      VS = 1;
      cyc();
      VS = 0;
      st_active = 1;
      cyc();
      chk("active_mem_en", 32'(mem_en), 0);
      chk("active_overflow", 32'(overflow), 0);
      chk("active_busy", 32'(busy), 0);
      // first sample: read at 0 wins, offset write to 293 follows
      drive(1, 0, 0, 3, -2);
      #1;
      chk("t1_rd_en", 32'(mem_en), 1);
      chk("t1_rd_we", 32'(mem_we), 0);
      chk("t1_rd_addr", 32'(mem_addr), 0);
      cyc();
      drive(0, 0, 0, 0, 0);
      #1;
      chk("t1_busy", 32'(busy), 1);
      chk("t1_wr_addr", 32'(mem_addr), 293);
      chk("t1_wr_data", 32'(mem_wdata), 10'b00011_11110);
      cyc();
      chk("t1_idle_busy", 32'(busy), 0);
      // read path: write {7,-1} to 21 through the DUT, then read it back
      drive(1, 256, 64, 7, -1);
      cyc();
      drive(0, 0, 0, 0, 0);
      cyc();
      drive(1, 32, 32, 0, 0);
      #1;
      chk("t2_addr", 32'(mem_addr), 21);
      chk("t2_we", 32'(mem_we), 0);
      cyc();
      drive(0, 0, 0, 0, 0);
      #1;
      chk("t2_disp_x", 32'(disp_vec_x), 7);
      chk("t2_disp_y", 32'(disp_vec_y), 5'h1f);
      chk("t2_disp_valid", 32'(disp_valid), 1);
      cyc();
      chk("t2_hold_valid", 32'(disp_valid), 0);
      chk("t2_hold_x", 32'(disp_vec_x), 7);
      // five samples under continuous reads: fifth dropped
      for (int i = 0; i < 5; i++) begin
         drive(1, i * 32, 64, i + 1, -(i + 1));
         cyc();
      end
      drive(0, 0, 0, 0, 0);
      VS = 1;
      #1;
      chk("t3_overflow", 32'(overflow), 1);
      chk("t3_drain_we", 32'(mem_we), 1);
      cyc();
      VS = 0;
      chk("t3_overflow_clr", 32'(overflow), 0);
      for (int i = 0; i < 4; i++) cyc();
      chk("t3_drained", 32'(exp_q.size()), 0);
      chk("t3_busy", 32'(busy), 0);
      // drop coinciding with a frame start keeps overflow set
      for (int i = 0; i < 5; i++) begin
         drive(1, 160 + i * 32, 96, i, i);
         VS = (i == 4);
         cyc();
      end
      VS = 0;
      drive(0, 0, 0, 0, 0);
      chk("t3b_overflow", 32'(overflow), 1);
      for (int i = 0; i < 4; i++) cyc();
      VS = 1;
      cyc();
      VS = 0;
      chk("t3b_overflow_clr", 32'(overflow), 0);
      // read vs pending write to addr 5
      drive(1, 384, 32, 1, 1);
      cyc();
      drive(0, 0, 0, 0, 0);
      cyc();
      drive(1, 384, 32, -5, 4);
      cyc();
      drive(1, 160, 1, 0, 0);
      #1;
      chk("t4_rd_addr", 32'(mem_addr), 5);
      chk("t4_rd_we", 32'(mem_we), 0);
      chk("t4_busy", 32'(busy), 1);
      cyc();
      drive(0, 0, 0, 0, 0);
      #1;
      chk("t4_old_x", 32'(disp_vec_x), 1);
      chk("t4_old_y", 32'(disp_vec_y), 1);
      chk("t4_wr_addr", 32'(mem_addr), 5);
      cyc();
      drive(1, 160, 1, 0, 0);
      cyc();
      drive(0, 0, 0, 0, 0);
      #1;
      chk("t4_new_x", 32'(disp_vec_x), 5'b11011);
      chk("t4_new_y", 32'(disp_vec_y), 4);
      cyc();
      // reset mid-drain with three pending entries
      for (int i = 0; i < 4; i++) begin
         drive(1, i * 32, 128, i, i);
         cyc();
      end
      drive(0, 0, 0, 0, 0);
      cyc();
      drive(1, 0, 1, 0, 0);
      rst = 1;
      #1;
      chk_zero("t5_rst");
      exp_q.delete();
      st_active = 0;
      pix_valid = 0;
      cyc();
      rst = 0;
`ifdef VEC_GRID_CLEAR_EN
      clear_sweep();
`endif
      for (int i = 0; i < 6; i++) cyc();
      chk("t5_busy", 32'(busy), 0);
      VS = 1;
      cyc();
      VS = 0;
      st_active = 1;
      drive(1, 0, 0, 2, 2);
      cyc();
      drive(0, 0, 0, 0, 0);
      #1;
      chk("t5_resume_we", 32'(mem_we), 1);
      cyc();
      chk("t5_resume_drained", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
